obi_timer: RTL

- Memory-mapped 64-bit timer/compare peripheral, a slave on the processor data bus (req/gnt/rvalid/we/be/addr/wdata/rdata/err).
- Instantiated inside peripheral_block next to GPIO and UART. Consumes bus transactions issued by processor_block.
- Drives a level interrupt output.
- Register map: CTRL, PRESCALE, MTIME lo/hi, MTIMECMP lo/hi, STATUS.

---
 rtl/microsoc_pkg.sv | 34 +++
 rtl/timer_prescaler.sv | 37 +++
 rtl/obi_timer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/microsoc_pkg.sv
// Shared definitions for the microsoc peripheral block.
// Timer register offsets, bit positions and a byte-enable merge helper.
package microsoc_pkg;

    localparam int BUS_DATA_W = 32;

    localparam int TIMER_CTRL_EN_BIT        = 0;
    localparam int TIMER_CTRL_IE_BIT        = 1;
    localparam int TIMER_STATUS_PENDING_BIT = 0;

    typedef enum logic [2:0] {
        TIMER_CTRL        = 3'd0,
        TIMER_PRESCALE    = 3'd1,
        TIMER_MTIME_LO    = 3'd2,
        TIMER_MTIME_HI    = 3'd3,
        TIMER_MTIMECMP_LO = 3'd4,
        TIMER_MTIMECMP_HI = 3'd5,
        TIMER_STATUS      = 3'd6,
        TIMER_RSVD        = 3'd7
    } timer_reg_e;

    function automatic logic [BUS_DATA_W-1:0] be_merge(
        input logic [BUS_DATA_W-1:0] old_v,
        input logic [BUS_DATA_W-1:0] new_v,
        input logic [3:0]            be
    );
        logic [BUS_DATA_W-1:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter for obi_timer.
// Emits a one-cycle tick every PRESCALE+1 enabled cycles.
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

    assign tick_o = en_i & (pcnt_q == prescale_i);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr_i) begin
            pcnt_d = '0;
        end else if (tick_o) begin
            pcnt_d = '0;
        end else if (en_i) begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/obi_timer.sv
// 64-bit mtime/mtimecmp timer on the processor data bus.
// Single-cycle accept, registered response one cycle later.
module obi_timer
    import microsoc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        data_err,
    output logic        timer_irq
);

    timer_reg_e off;
    logic       in_win, bad, wr;
    logic       unused_addr;
    logic       tick, pcnt_clr, stat_clr, cmp_hit;

    logic                  en_q, en_d, ie_q, ie_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           cmp_q, cmp_d;
    logic                  pend_q, pend_d;
    logic                  irq_q;

    logic                  rvalid_q;
    logic [BUS_DATA_W-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [BUS_DATA_W-1:0] pre_ext, pre_new;

    assign off         = timer_reg_e'(data_addr[4:2]);
    assign unused_addr = ^data_addr[1:0];
    assign in_win      = data_addr[31:5] == BASE_ADDR[31:5];
    assign bad         = ~in_win | (off == TIMER_RSVD);
    assign wr          = data_req & data_we & ~bad;

    assign data_gnt    = data_req;
    assign data_rvalid = rvalid_q;
    assign data_rdata  = rdata_q;
    assign data_err    = err_q;
    assign timer_irq   = irq_q;

    assign pcnt_clr = wr & (off == TIMER_PRESCALE);
    assign stat_clr = wr & (off == TIMER_STATUS)
                    & data_be[0] & data_wdata[TIMER_STATUS_PENDING_BIT];
    assign cmp_hit  = mtime_q >= cmp_q;

    timer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_q),
        .clr_i     (pcnt_clr),
        .prescale_i(pre_q),
        .tick_o    (tick)
    );

    always_comb begin
        pre_ext                 = '0;
        pre_ext[PRESCALE_W-1:0] = pre_q;
        pre_new                 = be_merge(pre_ext, data_wdata, data_be);
    end

    // Read data is taken from the state as it stands before this cycle's write.
    always_comb begin
        rdata_d = '0;
        err_d   = bad;
        if (!bad) begin
            unique case (off)
                TIMER_CTRL: begin
                    rdata_d[TIMER_CTRL_EN_BIT] = en_q;
                    rdata_d[TIMER_CTRL_IE_BIT] = ie_q;
                end
                TIMER_PRESCALE:    rdata_d = pre_ext;
                TIMER_MTIME_LO:    rdata_d = mtime_q[31:0];
                TIMER_MTIME_HI:    rdata_d = mtime_q[63:32];
                TIMER_MTIMECMP_LO: rdata_d = cmp_q[31:0];
                TIMER_MTIMECMP_HI: rdata_d = cmp_q[63:32];
                TIMER_STATUS:      rdata_d[TIMER_STATUS_PENDING_BIT] = pend_q;
                default:           rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        en_d    = en_q;
        ie_d    = ie_q;
        pre_d   = pre_q;
        mtime_d = mtime_q;
        cmp_d   = cmp_q;
        if (wr && off == TIMER_CTRL && data_be[0]) begin
            en_d = data_wdata[TIMER_CTRL_EN_BIT];
            ie_d = data_wdata[TIMER_CTRL_IE_BIT];
        end
        if (pcnt_clr) begin
            pre_d = pre_new[PRESCALE_W-1:0];
        end
        // A software write to mtime wins over the tick in the same cycle.
        if (wr && off == TIMER_MTIME_LO) begin
            mtime_d[31:0] = be_merge(mtime_q[31:0], data_wdata, data_be);
        end else if (wr && off == TIMER_MTIME_HI) begin
            mtime_d[63:32] = be_merge(mtime_q[63:32], data_wdata, data_be);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr && off == TIMER_MTIMECMP_LO) begin
            cmp_d[31:0] = be_merge(cmp_q[31:0], data_wdata, data_be);
        end
        if (wr && off == TIMER_MTIMECMP_HI) begin
            cmp_d[63:32] = be_merge(cmp_q[63:32], data_wdata, data_be);
        end
        pend_d = cmp_hit | (pend_q & ~stat_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            pre_q    <= '0;
            mtime_q  <= '0;
            cmp_q    <= '1;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            en_q     <= en_d;
            ie_q     <= ie_d;
            pre_q    <= pre_d;
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            pend_q   <= pend_d;
            irq_q    <= pend_q & ie_q;
            rvalid_q <= data_req;
            rdata_q  <= data_req ? rdata_d : '0;
            err_q    <= data_req & err_d;
        end
    end

endmodule
